// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package rr_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Pointer successor; wraps from n-1 back to 0.
  function automatic int next_ptr(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux_tree.sv
// N:1 data mux built as log2(N) levels of 2:1 muxes; select bit j drives level j.
module mux2 #(
  parameter int WIDTH = 8
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] y
);
  assign y = sel ? d1 : d0;
endmodule

module mux_tree #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic [$clog2(N)-1:0] sel,
  input  logic [N*WIDTH-1:0]   d,
  output logic [WIDTH-1:0]     y
);
  localparam int LVL = $clog2(N);

  // Level j holds N>>j words; level 0 is the raw input, level LVL the result.
  for (genvar j = 0; j <= LVL; j++) begin : g_lvl
    localparam int CNT = N >> j;
    logic [CNT*WIDTH-1:0] v;
    if (j == 0) begin : g_leaf
      assign v = d;
    end else begin : g_node
      for (genvar i = 0; i < CNT; i++) begin : g_mux
        mux2 #(.WIDTH(WIDTH)) u_mux2 (
          .sel (sel[j-1]),
          .d0  (g_lvl[j-1].v[(2*i)*WIDTH   +: WIDTH]),
          .d1  (g_lvl[j-1].v[(2*i+1)*WIDTH +: WIDTH]),
          .y   (v[i*WIDTH +: WIDTH])
        );
      end
    end
  end

  assign y = g_lvl[LVL].v;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output among N_REQ requesters.
module rr_mux_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [ID_W-1:0]    out_id,
  input  logic               out_ready
);

  state_t           state, state_nxt;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  gnt_idx;
  logic [ID_W-1:0]  cand;
  logic             gnt_found;
  logic             can_load;
  logic             load;
  logic [WIDTH-1:0] mux_y;

  assign out_valid = (state == FULL);
  assign can_load  = (state == EMPTY) | (out_valid & out_ready);

  // First valid requester at or after ptr; index arithmetic wraps since N_REQ is a power of two.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ptr + i[ID_W-1:0];
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && can_load && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  assign load = |(req_valid & req_ready);

  mux_tree #(.N(N_REQ), .WIDTH(WIDTH)) u_mux_tree (
    .sel (gnt_idx),
    .d   (req_data),
    .y   (mux_y)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (load) state_nxt = FULL;
      FULL:    if (load) state_nxt = FULL;
               else if (out_ready) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      ptr      <= '0;
      out_data <= '0;
      out_id   <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        out_data <= mux_y;
        out_id   <= gnt_idx;
        ptr      <= ID_W'(next_ptr(32'(gnt_idx), N_REQ));
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed table-driven bench for rr_mux_arbiter (N_REQ=4, WIDTH=8).
module tb_rr_mux_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int ID_W  = 2;
  localparam logic [31:0] D = 32'h44332211;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_REQ-1:0]       req_valid = '0;
  logic [N_REQ*WIDTH-1:0] req_data = '0;
  logic [N_REQ-1:0]       req_ready;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic [ID_W-1:0]        out_id;
  logic                   out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  rr_mux_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        ord;
    logic [3:0]  rdy;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  oid;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] v, input logic [31:0] d,
                     input logic o, input logic [3:0] rdy, input logic ov,
                     input logic [7:0] od, input logic [1:0] oid);
    vec_t t;
    t.rst = r; t.valid = v; t.data = d; t.ord = o;
    t.rdy = rdy; t.ov = ov; t.od = od; t.oid = oid;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  initial begin
    int  transfers;
    logic hit;

    // Rows: inputs applied for one cycle; expectations sampled before that cycle's edge.
    //   rst v      data          ord rdy     ov od     id
    add(1, 4'b1111, D,            1, 4'b0000, 0, 8'h00, 0);  // 0 reset held
    add(0, 4'b0100, 32'h44A52211, 1, 4'b0100, 0, 8'h00, 0);  // 1 single requester 2
    add(0, 4'b0000, D,            1, 4'b0000, 1, 8'hA5, 2);  // 2 output A5/2, drain
    add(0, 4'b1111, D,            1, 4'b1000, 0, 8'hA5, 2);  // 3 search starts at 3
    add(0, 4'b1111, D,            1, 4'b0001, 1, 8'h44, 3);  // 4
    add(0, 4'b1111, D,            1, 4'b0010, 1, 8'h11, 0);  // 5 streaming 0,1,2,3,...
    add(0, 4'b1111, D,            1, 4'b0100, 1, 8'h22, 1);  // 6
    add(0, 4'b1111, D,            1, 4'b1000, 1, 8'h33, 2);  // 7
    add(0, 4'b1111, D,            1, 4'b0001, 1, 8'h44, 3);  // 8
    add(0, 4'b1111, D,            1, 4'b0010, 1, 8'h11, 0);  // 9
    add(0, 4'b1111, D,            1, 4'b0100, 1, 8'h22, 1);  // 10
    add(0, 4'b1111, D,            1, 4'b1000, 1, 8'h33, 2);  // 11
    add(0, 4'b0010, 32'h44333C11, 1, 4'b0010, 1, 8'h44, 3);  // 12 load id1 = 3C
    add(0, 4'b0100, 32'h44333C11, 0, 4'b0000, 1, 8'h3C, 1);  // 13 backpressure
    add(0, 4'b0100, 32'h44333C11, 0, 4'b0000, 1, 8'h3C, 1);  // 14
    add(0, 4'b0100, 32'h44333C11, 0, 4'b0000, 1, 8'h3C, 1);  // 15
    add(0, 4'b0100, 32'h44333C11, 1, 4'b0100, 1, 8'h3C, 1);  // 16 drain + load id2
    add(0, 4'b0000, D,            1, 4'b0000, 1, 8'h33, 2);  // 17 drain, ptr=3
    add(0, 4'b0010, D,            1, 4'b0010, 0, 8'h33, 2);  // 18 wrap to id1
    add(0, 4'b1010, D,            1, 4'b1000, 1, 8'h22, 1);  // 19 skip 2, grant 3
    add(0, 4'b0000, D,            0, 4'b0000, 1, 8'h44, 3);  // 20 hold, ptr=0
    add(0, 4'b1111, D,            1, 4'b0001, 1, 8'h44, 3);  // 21 grant from 0
    add(0, 4'b0100, D,            1, 4'b0100, 1, 8'h11, 0);  // 22 load id2
    add(0, 4'b1111, D,            0, 4'b0000, 1, 8'h33, 2);  // 23 full, stalled
    add(1, 4'b1111, D,            0, 4'b0000, 1, 8'h33, 2);  // 24 reset mid-operation
    add(0, 4'b1111, D,            0, 4'b0001, 0, 8'h00, 0);  // 25 first grant from 0
    add(0, 4'b0000, D,            0, 4'b0000, 1, 8'h11, 0);  // 26

    rst = 1'b1; req_valid = 4'b1111; req_data = D; out_ready = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; req_valid = vecs[i].valid;
      req_data = vecs[i].data; out_ready = vecs[i].ord;
      #1;
      check("req_ready", i, 32'(req_ready), 32'(vecs[i].rdy));
      check("out_valid", i, 32'(out_valid), 32'(vecs[i].ov));
      check("out_data",  i, 32'(out_data),  32'(vecs[i].od));
      check("out_id",    i, 32'(out_id),    32'(vecs[i].oid));
    end

    // Fairness: state is FULL with ptr=1; with everyone requesting, id3 wins after ids 1 and 2.
    @(negedge clk);
    rst = 1'b0; req_valid = 4'b1111; req_data = D; out_ready = 1'b1;
    transfers = 0;
    hit = 1'b0;
    for (int c = 0; c < 2 * N_REQ; c++) begin
      #1;
      if (req_ready[3]) begin
        hit = 1'b1;
        break;
      end
      if (|req_ready) transfers++;
      @(negedge clk);
    end
    check("fair_hit", 100, 32'(hit), 32'd1);
    check("fair_count", 100, 32'(transfers), 32'd2);
    check("no_bubble", 100, 32'(out_valid), 32'd1);
    check("stream_id", 100, 32'(out_id), 32'd2);

    @(negedge clk);
    req_valid = '0;
    #1;
    check("last_id", 101, 32'(out_id), 32'd3);
    check("last_data", 101, 32'(out_data), 32'h44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one registered output channel between N_REQ requesters.
- Drives the select of an N_REQ:1 data mux built from 2:1 mux stages.
- Valid/ready handshake on every input and on the output.
- Sits between several producer blocks and a single downstream consumer. Provides one-entry buffering and full throughput, one transfer per cycle.

Parameters:
- N_REQ, 4, number of requesters; power of two, 2..16.
- WIDTH, 8, data width per requester.
- ID_W, $clog2(N_REQ), width of the requester index.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  N_REQ  per-requester valid.
- req_data  input  N_REQ*WIDTH  packed request data; requester k occupies bits [k*WIDTH +: WIDTH].
- req_ready  output  N_REQ  per-requester ready; one-hot or zero.
- out_valid  output  1  output register holds data.
- out_data  output  WIDTH  registered data of granted requester.
- out_id  output  ID_W  index of the requester that supplied out_data.
- out_ready  input  1  downstream accepts.

Behaviour:
- Reset (rst=1 at clock edge):
  - out_valid=0, out_data=0, out_id=0, priority pointer ptr=0, state=EMPTY.
  - req_ready is forced to 0 combinationally while rst=1.
- State machine, two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- can_load = (state==EMPTY) | (out_valid & out_ready).
- Grant (combinational):
  - When can_load is 1 and any req_valid is 1, grant the first valid requester scanning ptr, ptr+1, ..., ptr+N_REQ-1, modulo N_REQ.
  - req_ready[g]=1 for the granted g only; all other req_ready bits are 0.
  - req_ready is 0 whenever can_load is 0.
  - req_ready may depend combinationally on req_valid and out_ready.
- Transfer on input k occurs when req_valid[k] & req_ready[k]. On that clock edge:
  - out_data <= req_data[k]
  - out_id <= k
  - out_valid <= 1
  - ptr <= (k+1) mod N_REQ, wrapping from N_REQ-1 to 0.
- Latency: one cycle from input transfer to out_valid.
- Drain without a new load (out_valid & out_ready, no req_valid): out_valid <= 0 and state goes to EMPTY. out_data and out_id hold their old values. ptr is unchanged.
- Simultaneous drain and load in the same cycle: state stays FULL and the new data replaces the old. No bubble, so sustained throughput is one word per cycle.
- Backpressure (FULL & !out_ready):
  - out_data and out_id are stable; all req_ready are 0; ptr is unchanged.
  - Requesters must hold req_valid and req_data until accepted. The arbiter does not check this.
- ptr advances only on a grant. It never advances on idle cycles.
- Fairness: any requester with req_valid held high is granted within N_REQ output transfers.
- Reset mid-operation: any buffered word is discarded with no output handshake, and the first grant after reset goes from ptr=0.
- Data path:
  - The selected word is chosen by an N_REQ:1 mux tree. The mux select is the binary grant index.
  - The tree has log2(N_REQ) levels of the team's 2:1 mux, where y = sel ? d1 : d0.
  - Select bit j drives level j.

Decomposition:
- Package rr_arb_pkg:
  - enum state_t {EMPTY, FULL}
  - function next_ptr(idx, n), returning (idx+1) mod n.
- Sub-module mux_tree (parameters N, WIDTH; ports sel[$clog2(N)], packed d, y) built by generate from 2:1 mux instances.
- Priority search and pointer logic stay in rr_mux_arbiter.

Test Plan:
- Reset check: hold rst=1 for 2 cycles with all req_valid=1 -> out_valid=0, out_data=0, out_id=0, req_ready=0000.
- Single requester: after reset, req_valid=0100, data2=8'hA5, out_ready=1 -> req_ready=0100 in the same cycle. Next cycle out_valid=1, out_data=A5, out_id=2. Next grant starts searching from index 3.
- All requesting, out_ready=1 for 8 cycles -> out_id sequence 0,1,2,3,0,1,2,3 with one word per cycle and no bubbles.
- Backpressure:
  - Load id 1 with data 8'h3C, then set out_ready=0 for 3 cycles -> out_data stays 3C, out_id stays 1, req_ready=0000.
  - Raise out_ready -> the next grant goes to id 2 in the same cycle as the drain.
- Wrap and skip: ptr=3, req_valid=0010 -> grant id 1 and ptr becomes 2. Then req_valid=1010 -> grant id 3 and ptr becomes 0.
- Reset mid-operation: FULL with out_id=2 and out_ready=0, assert rst for 1 cycle -> out_valid=0. With req_valid=1111 afterwards, the first out_id=0.
